// File: rtl/ras_stack_pkg.sv
// ras_stack_pkg
//   Shared types and sizing for the fetch-predictor return address stack.
//   RAS_ENTRIES must be a power of two so that index arithmetic wraps
//   naturally in LOG_RAS_ENTRIES bits.
package ras_stack_pkg;

  localparam int RAS_ENTRIES     = 16;
  localparam int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES);

  typedef logic [37:0]                PC38_t;
  typedef logic [LOG_RAS_ENTRIES-1:0] RAS_idx_t;
  typedef logic [LOG_RAS_ENTRIES:0]   RAS_cnt_t;

  // Checkpoint captured into a BCB entry and handed back on restore.
  typedef struct packed {
    RAS_idx_t ras_index;
    RAS_cnt_t ras_count;
  } ras_ckpt_t;

  localparam PC38_t    INIT_PC38    = '0;
  localparam RAS_cnt_t RAS_FULL_CNT = RAS_cnt_t'(RAS_ENTRIES);
  localparam RAS_cnt_t RAS_CNT_ONE  = RAS_cnt_t'(1);
  localparam RAS_idx_t RAS_IDX_ONE  = RAS_idx_t'(1);

endpackage

// File: rtl/ras_stack_if.sv
// ras_stack_if
//   Predictor <-> return-address-stack signal bundle.
//   master : fetch-predict stage (drives push/pop/restore, reads top of stack)
//   slave  : ras_stack
//   Signals:
//     push_valid/push_pc38    link action and its return address
//     pop_valid               return action
//     ret_valid/ret_pc38      stack non-empty / current top entry
//     ras_index/ras_count     checkpoint exported for BCB capture
//     restore_*               checkpoint returned on mispredict
interface ras_stack_if;
  import ras_stack_pkg::*;

  logic     push_valid;
  PC38_t    push_pc38;
  logic     pop_valid;
  logic     ret_valid;
  PC38_t    ret_pc38;
  RAS_idx_t ras_index;
  RAS_cnt_t ras_count;
  logic     restore_valid;
  RAS_idx_t restore_ras_index;
  RAS_cnt_t restore_ras_count;

  modport master (
    output push_valid, push_pc38, pop_valid,
           restore_valid, restore_ras_index, restore_ras_count,
    input  ret_valid, ret_pc38, ras_index, ras_count
  );

  modport slave (
    input  push_valid, push_pc38, pop_valid,
           restore_valid, restore_ras_index, restore_ras_count,
    output ret_valid, ret_pc38, ras_index, ras_count
  );

endinterface

// File: rtl/ras_stack.sv
// ras_stack
//   16-entry return address stack for the fetch predictor.
//   Ports:
//     CLK           clock
//     RST           synchronous active-high reset
//     ras           ras_stack_if.slave (push/pop/restore in, top/checkpoint out)
//     overflow_cnt  [7:0] saturating overflow/underflow event counter,
//                   present only when RAS_OVERFLOW_CNT_EN is defined
//   Outputs are straight reads of state flops; updates appear the cycle
//   after the event. Per-cycle priority: restore > push+pop > push > pop.
module ras_stack
  import ras_stack_pkg::*;
(
  input logic        CLK,
  input logic        RST,
  ras_stack_if.slave ras
`ifdef RAS_OVERFLOW_CNT_EN
  ,
  output logic [7:0] overflow_cnt
`endif
);

  PC38_t    ras_mem [RAS_ENTRIES];
  RAS_idx_t ras_index_q;
  RAS_cnt_t ras_count_q;

  logic     empty;
  logic     full;
  RAS_idx_t idx_inc;

  assign empty   = (ras_count_q == '0);
  assign full    = (ras_count_q == RAS_FULL_CNT);
  assign idx_inc = ras_index_q + RAS_IDX_ONE;

  assign ras.ret_valid = !empty;
  assign ras.ret_pc38  = ras_mem[ras_index_q];
  assign ras.ras_index = ras_index_q;
  assign ras.ras_count = ras_count_q;

  // Pop never clears entries: a later restore may legitimately re-expose
  // them during branch recovery.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ras_index_q <= '0;
      ras_count_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) ras_mem[i] <= INIT_PC38;
    end else if (ras.restore_valid) begin
      ras_index_q <= ras.restore_ras_index;
      ras_count_q <= (ras.restore_ras_count > RAS_FULL_CNT) ? RAS_FULL_CNT
                                                            : ras.restore_ras_count;
    end else if (ras.push_valid && ras.pop_valid && !empty) begin
      // Return-and-link: replace top in place.
      ras_mem[ras_index_q] <= ras.push_pc38;
    end else if (ras.push_valid) begin
      // When full the wrapped index lands on the oldest entry.
      ras_index_q      <= idx_inc;
      ras_mem[idx_inc] <= ras.push_pc38;
      if (!full) ras_count_q <= ras_count_q + RAS_CNT_ONE;
    end else if (ras.pop_valid && !empty) begin
      ras_index_q <= ras_index_q - RAS_IDX_ONE;
      ras_count_q <= ras_count_q - RAS_CNT_ONE;
    end
  end

`ifdef RAS_OVERFLOW_CNT_EN
  logic ovf_event;

  assign ovf_event = !ras.restore_valid &&
                     ((ras.push_valid && !ras.pop_valid && full) ||
                      (ras.pop_valid && !ras.push_valid && empty));

  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_cnt <= '0;
    end else if (ovf_event && (overflow_cnt != 8'hFF)) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack
//   Directed sequences followed by random traffic. The driver updates a
//   behavioural stack model for every cycle it drives and queues the
//   expected post-edge state; a monitor pops and compares after each edge.
module tb_ras_stack;
  import ras_stack_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ras_stack_if ras ();
`ifdef RAS_OVERFLOW_CNT_EN
  logic [7:0] overflow_cnt;
`endif

  ras_stack dut (
    .CLK (CLK),
    .RST (RST),
    .ras (ras.slave)
`ifdef RAS_OVERFLOW_CNT_EN
    ,
    .overflow_cnt (overflow_cnt)
`endif
  );

  typedef struct {
    string       tag;
    logic        ret_valid;
    logic [37:0] ret_pc38;
    int          idx;
    int          cnt;
    int          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: plain integers with explicit modulo wrap.
  logic [37:0] m_mem [16];
  int          m_idx = 0;
  int          m_cnt = 0;
  int          m_ovf = 0;

  function automatic void chk(string nm, longint got, longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endfunction

  task automatic step(input string tag, input bit rst, input bit push,
                      input logic [37:0] pc, input bit pop, input bit rv,
                      input int ri, input int rc);
    exp_t e;
    @(negedge CLK);
    RST                   = rst;
    ras.push_valid        = push;
    ras.push_pc38         = pc;
    ras.pop_valid         = pop;
    ras.restore_valid     = rv;
    ras.restore_ras_index = RAS_idx_t'(ri);
    ras.restore_ras_count = RAS_cnt_t'(rc);
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_ovf = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end else if (rv) begin
      m_idx = ri % 16;
      m_cnt = (rc > 16) ? 16 : rc;
    end else if (push && pop && m_cnt != 0) begin
      m_mem[m_idx] = pc;
    end else if (push) begin
      if (!pop && m_cnt == 16 && m_ovf < 255) m_ovf++;
      m_idx = (m_idx + 1) % 16;
      m_mem[m_idx] = pc;
      if (m_cnt < 16) m_cnt++;
    end else if (pop) begin
      if (m_cnt != 0) begin
        m_idx = (m_idx + 15) % 16;
        m_cnt--;
      end else if (m_ovf < 255) begin
        m_ovf++;
      end
    end
    e.tag       = tag;
    e.ret_valid = (m_cnt != 0);
    e.ret_pc38  = m_mem[m_idx];
    e.idx       = m_idx;
    e.cnt       = m_cnt;
    e.ovf       = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, '0, 0, 0, 0, 0);
  endtask
  task automatic push(input string tag, input logic [37:0] pc);
    step(tag, 0, 1, pc, 0, 0, 0, 0);
  endtask
  task automatic pop(input string tag);
    step(tag, 0, 0, '0, 1, 0, 0, 0);
  endtask
  task automatic rst1();
    step("reset", 1, 0, '0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, compared one edge after drive.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".ret_valid"}, longint'(ras.ret_valid), longint'(e.ret_valid));
      chk({e.tag, ".ret_pc38"},  longint'(ras.ret_pc38),  longint'(e.ret_pc38));
      chk({e.tag, ".ras_index"}, longint'(ras.ras_index), longint'(e.idx));
      chk({e.tag, ".ras_count"}, longint'(ras.ras_count), longint'(e.cnt));
`ifdef RAS_OVERFLOW_CNT_EN
      chk({e.tag, ".overflow_cnt"}, longint'(overflow_cnt), longint'(e.ovf));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int snap_idx, snap_cnt;
    ras.push_valid = 0; ras.push_pc38 = '0; ras.pop_valid = 0;
    ras.restore_valid = 0; ras.restore_ras_index = '0; ras.restore_ras_count = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;

    rst1();
    idle("post_reset");
    push("push100", 38'h100);
    push("push200", 38'h200);
    pop("pop_basic");

    rst1();
    for (int i = 1; i <= 17; i++) push("fill", 38'(i));
    for (int i = 0; i < 16; i++) pop("drain");
    pop("underflow");
    idle("underflow_hold");

    rst1();
    push("pushA", 38'hA);
    step("retl_B", 0, 1, 38'hB, 1, 0, 0, 0);
    rst1();
    step("retl_empty", 0, 1, 38'h5, 1, 0, 0, 0);

    rst1();
    push("push10", 38'h10);
    push("push20", 38'h20);
    snap_idx = m_idx; snap_cnt = m_cnt;
    push("push30", 38'h30);
    pop("pop1");
    pop("pop2");
    step("restore_w_push", 0, 1, 38'h999, 0, 1, snap_idx, snap_cnt);
    idle("restore_hold");
    step("restore_clamp", 0, 0, '0, 1, 1, 3, 20);

    rst1();
    push("p1", 38'h1); push("p2", 38'h2); push("p3", 38'h3);
    step("rst_with_push", 1, 1, 38'h44, 0, 0, 0, 0);
    idle("after_rst_push");

    snap_idx = 0; snap_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [37:0] v;
      r = int'($urandom_range(0, 99));
      v = {6'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) begin
        snap_idx = m_idx; snap_cnt = m_cnt;
      end
      if (r < 2)       rst1();
      else if (r < 8)  step("rnd_restore", 0, $urandom_range(0, 1), v,
                            $urandom_range(0, 1), 1, snap_idx, snap_cnt);
      else if (r < 11) step("rnd_restore_any", 0, 0, v, 0, 1,
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
      else if (r < 45) push("rnd_push", v);
      else if (r < 80) pop("rnd_pop");
      else if (r < 92) step("rnd_retl", 0, 1, v, 1, 0, 0, 0);
      else             idle("rnd_idle");
    end

    @(negedge CLK);
    @(negedge CLK);
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Fetch-predictor return address stack, 16 entries of PC38_t.
- Consumes BTB_ACTION_JUMP_L/RET/RET_L/INDIRECT_L decisions from the fetch-predict stage.
- Supplies ret_pc38 to the fetch pc38 mux.
- Exports {ras_index, ras_count} for capture into BCB entries, and accepts them back on branch-mispredict restore.

Parameters:
- RAS_ENTRIES, 16, stack depth; power of 2.
- LOG_RAS_ENTRIES, $clog2(RAS_ENTRIES), index width.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- push_valid  input  1  link action; push push_pc38
- push_pc38  input  38  return address (PC38_t)
- pop_valid  input  1  return action; pop top
- ret_valid  output  1  stack non-empty (ras_count != 0)
- ret_pc38  output  38  current top entry
- ras_index  output  LOG_RAS_ENTRIES  current top pointer (RAS_idx_t)
- ras_count  output  LOG_RAS_ENTRIES+1  valid entries, 0..RAS_ENTRIES (RAS_cnt_t)
- restore_valid  input  1  mispredict restore
- restore_ras_index  input  LOG_RAS_ENTRIES  index from BCB entry
- restore_ras_count  input  LOG_RAS_ENTRIES+1  count from BCB entry

Behaviour:
- Reset: one clock, synchronous active-high (CLK rising edge, RST=1).
  - On reset: ras_index=0, ras_count=0, all array entries=INIT_PC38 (38'h0), ret_valid=0, ret_pc38=38'h0.
- Outputs are combinational reads of state flops. An update is visible the cycle after the event; there is no same-cycle bypass.
- Top entry = array[ras_index]. Index arithmetic is modulo RAS_ENTRIES (natural wrap).
- Events are evaluated per cycle in this priority order:
  1. restore_valid: ras_index<=restore_ras_index; ras_count<=restore_ras_count. Push and pop are ignored that cycle and the array is untouched. A restore_ras_count > RAS_ENTRIES is clamped to RAS_ENTRIES.
  2. push_valid & pop_valid (RET_L / coroutine):
     - ras_count != 0: array[ras_index]<=push_pc38; index and count unchanged.
     - ras_count == 0: behave as push only.
  3. push_valid only: ras_index<=ras_index+1; array[ras_index+1]<=push_pc38; ras_count<=min(ras_count+1, RAS_ENTRIES).
     - When full, the oldest entry is overwritten silently and count stays at RAS_ENTRIES.
  4. pop_valid only:
     - ras_count != 0: ras_index<=ras_index-1; ras_count<=ras_count-1.
     - ras_count == 0: no state change (underflow ignored; ret_valid already 0).
  5. None: hold.
- Stale array contents are never cleared on pop; a restore may re-expose them, which is intended for BCB recovery.
- Reset asserted mid-sequence overrides every event that cycle.

Optional Feature:
- Macro: RAS_OVERFLOW_CNT_EN.
- Defined:
  - Adds output overflow_cnt [7:0].
  - Increments, saturating at 8'hFF, on each cycle in which a push-only occurs while ras_count==RAS_ENTRIES.
  - Also increments on each pop-only while ras_count==0 (underflow).
  - Reset to 0.
  - Not affected by restore.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package (corep): RAS_ENTRIES, LOG_RAS_ENTRIES, RAS_idx_t, RAS_cnt_t, PC38_t, INIT_PC38.
- BCB_entry_t already carries ras_index/ras_count and is reused unchanged.
- No sub-module. The 16x38 flop array and the pointer logic are a single module.

Test Plan:
- Reset, then push 38'h100, 38'h200 -> ras_index=2, ras_count=2, ret_pc38=38'h200, ret_valid=1; pop -> ret_pc38=38'h100, count=1.
- From reset, 17 pushes of values 1..17 -> count=16, ras_index=1, ret_pc38=17. Then 16 pops -> count=0, ret_valid=0, and a further pop leaves index/count unchanged (overflow_cnt=2 if RAS_OVERFLOW_CNT_EN).
- Push 38'hA, then push+pop of 38'hB in the same cycle -> count=1, index=1, ret_pc38=38'hB; simultaneous push+pop at count=0 -> count=1, index=1.
- Push 38'h10, 38'h20, capture {index=2,count=2}, push 38'h30, pop, pop, then restore with push_valid also high -> index=2, count=2, ret_pc38=38'h20, array unchanged by push.
- Restore with restore_ras_count=5'd20 -> ras_count=16 (clamped).
- RST asserted in the same cycle as push_valid with count=3 -> index=0, count=0, ret_pc38=0 next cycle.
